sram_window_reader: RTL and testbench
=====================================

// Module: sram_window_reader
// PURPOSE
//  Read master for the single-port frame SRAM (en/we/addr/data_in, registered data_out, 1-cycle read latency).
//  Raster-scans a rectangular pixel window and streams the pixels out on a valid/ready interface.
//  Carries SOF/EOL/EOF markers on the stream.
//  Sits between the frame store and downstream pixel-processing stages; the SRAM is never written from this block.
// PARAMETERS
//  IMG_W      1024  frame width in pixels (power of 2); address = y*IMG_W + x
//  IMG_H      1024  frame height in pixels
//  ADDR_SZ    20    SRAM address width = log2(IMG_W*IMG_H)
//  RAM_WIDTH  24    pixel / SRAM data width
// PORTS
//  clk        in   1            single clock, all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  start      in   1            1-cycle request; sampled only in IDLE
//  x0         in   log2(IMG_W)  window left column, latched on accepted start
//  y0         in   log2(IMG_H)  window top row, latched on accepted start
//  win_w      in   log2(IMG_W)+1  window width in pixels (1..IMG_W)
//  win_h      in   log2(IMG_H)+1  window height in pixels (1..IMG_H)
//  sram_en    out  1            SRAM enable; high only in cycles that issue a read
//  sram_we    out  1            constant 0
//  sram_addr  out  ADDR_SZ      read address, valid when sram_en=1
//  sram_wdata out  RAM_WIDTH    constant 0
//  sram_rdata in   RAM_WIDTH    SRAM data_out; valid the cycle after a read issue
//  pix_valid  out  1            output pixel valid
//  pix_ready  in   1            downstream ready; transfer when valid&ready
//  pix_data   out  RAM_WIDTH    pixel value
//  pix_sof    out  1            first pixel of window (qualified by pix_valid)
//  pix_eol    out  1            last pixel of a window row
//  pix_eof    out  1            last pixel of window
//  busy       out  1            high from accepted start until done
//  done       out  1            1-cycle pulse at end of operation
//  err        out  1            high together with done when request was rejected
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, 2-entry output FIFO and pending-read flag cleared. Reset mid-frame aborts immediately; no done pulse.
//  FSM: IDLE -> (start) CHECK -> RUN | DONE(err); RUN -> DRAIN after last read issued;
//   DRAIN -> DONE when FIFO empty and no read pending; DONE -> IDLE (done=1 for exactly this cycle).
//  CHECK rejects (err=1, no SRAM access) if win_w==0, win_h==0, x0+win_w>IMG_W or y0+win_h>IMG_H.
//   All sums are computed one bit wider so they cannot overflow.
//  start while busy is ignored; window inputs are latched only on an accepted start.
//  Scan order: x from x0 to x0+win_w-1, then y+1 and x back to x0. sram_addr = {y, x}. No wrap past frame edge.
//  Read latency: read issued in cycle t (sram_en=1); sram_rdata is captured into the FIFO at the end of cycle t+1.
//   pix_valid is therefore high from cycle t+2. The first read issue is 2 cycles after the cycle start is sampled.
//  Flow control: issue a read in cycle t only if fifo_count + pending - pop_t < 2.
//   pop_t = pix_valid & pix_ready. This guarantees no overflow and no lost rdata.
//  With pix_ready held at 1, throughput is 1 pixel/cycle sustained.
//  pix_valid, once high, stays high with stable data and markers until accepted (AXI-style).
//  Markers travel in the FIFO alongside the data:
//   sof = (x==x0 & y==y0); eol = (x==last col); eof = eol & (y==last row).
//  done asserts the cycle after the eof pixel is accepted; busy drops with done.
// TESTING
//  1. x0=0,y0=0,w=2,h=2, ready=1 -> addr 0,1,1024,1025 on consecutive sram_en cycles; 4 pixels in order;
//     sof on #1, eol on #2/#4, eof on #4; done 1 cycle after #4.
//  2. x0=5,y0=3,w=4,h=1, ready toggled 1/0 each cycle -> addr 3077..3080; every pixel delivered exactly once;
//     pix_data stable while stalled; FIFO never overflows.
//  3. x0=1020,y0=1023,w=4,h=1 -> addr 1048572..1048575, eof on last; no address wrap.
//  4. w=0, then x0=1000,w=25 -> done=1,err=1 one cycle after CHECK; sram_en never asserted; busy low afterwards.
//  5. start pulsed again mid-frame -> ignored; rst mid-frame -> all outputs 0 next cycle; subsequent 1x1 request at (7,7) reads addr 7175.
//  6. x0=0,y0=0,w=16,h=16, ready=1 -> 256 pixels on 256 consecutive cycles after the first pix_valid.

Source files
------------

// File: rtl/sram_window_reader.sv
// -----------------------------------------------------------------------------
// sram_window_reader
//
// Read master for the single-port frame SRAM. It raster-scans a rectangular
// pixel window and streams the pixels downstream with SOF/EOL/EOF markers.
// The SRAM is never written from this block.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   start                 1-cycle request, sampled only while idle
//   x0, y0                window top-left corner (latched on accepted start)
//   win_w, win_h          window size in pixels (latched on accepted start)
//   sram_en/we/addr/wdata SRAM request side (we and wdata tied to 0)
//   sram_rdata            SRAM registered read data (1-cycle latency)
//   pix_valid/ready       output stream handshake
//   pix_data              pixel value
//   pix_sof/eol/eof       frame/row markers, qualified by pix_valid
//   busy                  high from accepted start until done
//   done                  1-cycle pulse at end of operation
//   err                   high with done when the request was rejected
//   dbg_state             current FSM state
//
// Stream handshake: a pixel transfers in every cycle where pix_valid and
// pix_ready are both high. Once pix_valid rises it stays high, and pix_data
// and the markers stay stable, until that transfer happens.
// -----------------------------------------------------------------------------
module sram_window_reader #(
    parameter int IMG_W     = 1024,
    parameter int IMG_H     = 1024,
    parameter int ADDR_SZ   = 20,
    parameter int RAM_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(IMG_W)-1:0]  x0,
    input  logic [$clog2(IMG_H)-1:0]  y0,
    input  logic [$clog2(IMG_W):0]    win_w,
    input  logic [$clog2(IMG_H):0]    win_h,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [ADDR_SZ-1:0]        sram_addr,
    output logic [RAM_WIDTH-1:0]      sram_wdata,
    input  logic [RAM_WIDTH-1:0]      sram_rdata,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [RAM_WIDTH-1:0]      pix_data,
    output logic                      pix_sof,
    output logic                      pix_eol,
    output logic                      pix_eof,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                dbg_state
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = RAM_WIDTH + 3;
    localparam logic [XW+1:0] IMG_W_EXT = (XW+2)'(IMG_W);
    localparam logic [YW+1:0] IMG_H_EXT = (YW+2)'(IMG_H);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nx;

    // Latched request
    logic [XW-1:0] x0_q;
    logic [YW-1:0] y0_q;
    logic [XW:0]   w_q;
    logic [YW:0]   h_q;
    logic          rej_q;

    // Scan position
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Read in flight and the markers that belong to it
    logic          pend_q;
    logic [2:0]    pend_mk;

    // 2-entry output FIFO: {sof, eol, eof, data}
    logic [FW-1:0] fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;
    logic [FW-1:0] head;

    logic          issue, pop, room, reject;
    logic [2:0]    cnt_after;
    logic [XW+1:0] x_sum;
    logic [YW+1:0] y_sum;
    logic [XW-1:0] x_last;
    logic [YW-1:0] y_last;
    logic          at_last_col, at_last_row, cur_sof;

    // Window bounds; sums are two bits wider than the coordinate so the
    // comparison against the frame size cannot overflow.
    assign x_sum  = {2'b00, x0_q} + {1'b0, w_q};
    assign y_sum  = {2'b00, y0_q} + {1'b0, h_q};
    assign reject = (w_q == '0) || (h_q == '0) || (x_sum > IMG_W_EXT) || (y_sum > IMG_H_EXT);
    assign x_last = x0_q + w_q[XW-1:0] - X_ONE;
    assign y_last = y0_q + h_q[YW-1:0] - Y_ONE;

    assign at_last_col = (x_q == x_last);
    assign at_last_row = (y_q == y_last);
    assign cur_sof     = (x_q == x0_q) && (y_q == y0_q);

    assign pix_valid = (fifo_cnt != 2'd0);
    assign pop       = pix_valid & pix_ready;
    assign head      = fifo_mem[rd_ptr];

    // Occupancy the FIFO will have next cycle, counting the read in flight.
    // A new read is only issued when that leaves a free slot for its data.
    assign cnt_after = {1'b0, fifo_cnt} + {2'b00, pend_q} - {2'b00, pop};
    assign room      = (cnt_after < 3'd2);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_CHECK;
            end
            S_CHECK: begin
                busy     = 1'b1;
                state_nx = reject ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (room) begin
                    issue = 1'b1;
                    if (at_last_col && at_last_row) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Finish once the last pixel leaves; done then follows the
                // eof transfer by exactly one cycle.
                if (cnt_after == 3'd0 && !pend_q) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                err      = rej_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign dbg_state  = state;
    assign sram_en    = issue;
    assign sram_we    = 1'b0;
    assign sram_wdata = '0;
    assign sram_addr  = issue ? {y_q, x_q} : '0;

    assign pix_data = pix_valid ? head[RAM_WIDTH-1:0] : '0;
    assign pix_sof  = pix_valid & head[FW-1];
    assign pix_eol  = pix_valid & head[FW-2];
    assign pix_eof  = pix_valid & head[FW-3];

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            rej_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            pend_q   <= 1'b0;
            pend_mk  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (state == S_IDLE && start) begin
                x0_q <= x0;
                y0_q <= y0;
                w_q  <= win_w;
                h_q  <= win_h;
                x_q  <= x0;
                y_q  <= y0;
            end
            if (state == S_CHECK) rej_q <= reject;

            if (issue) begin
                pend_mk <= {cur_sof, at_last_col, at_last_col & at_last_row};
                if (at_last_col) begin
                    x_q <= x0_q;
                    if (!at_last_row) y_q <= y_q + Y_ONE;
                end else begin
                    x_q <= x_q + X_ONE;
                end
            end
            pend_q <= issue;

            if (pend_q) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, pend_q} - {1'b0, pop};
        end
    end

    // Read data is captured the cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (pend_q) fifo_mem[wr_ptr] <= {pend_mk, sram_rdata};
    end

endmodule

// File: tb/tb_sram_window_reader.sv
module tb_sram_window_reader;
    localparam int IMG_W   = 1024;
    localparam int IMG_H   = 1024;
    localparam int ADDR_SZ = 20;
    localparam int RW      = 24;

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [9:0]        x0 = '0;
    logic [9:0]        y0 = '0;
    logic [10:0]       win_w = '0;
    logic [10:0]       win_h = '0;
    logic              sram_en, sram_we;
    logic [ADDR_SZ-1:0] sram_addr;
    logic [RW-1:0]     sram_wdata;
    logic [RW-1:0]     sram_rdata = '0;
    logic              pix_valid;
    logic              pix_ready = 1'b1;
    logic [RW-1:0]     pix_data;
    logic              pix_sof, pix_eol, pix_eof;
    logic              busy, done, err;
    logic [2:0]        dbg_state;

    sram_window_reader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_SZ(ADDR_SZ), .RAM_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .win_w(win_w), .win_h(win_h),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    logic [ADDR_SZ+2*RW+9:0] all_out;
    assign all_out = {sram_en, sram_we, sram_addr, sram_wdata, pix_valid, pix_data,
                      pix_sof, pix_eol, pix_eof, busy, done, err};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------- SRAM model
    logic [RW-1:0] salt = '0;

    function automatic logic [RW-1:0] mem_word(input logic [ADDR_SZ-1:0] a);
        return {a[3:0], a} ^ salt;
    endfunction

    always @(posedge clk) if (sram_en) sram_rdata <= mem_word(sram_addr);

    // ------------------------------------------------- ready driver
    int ready_mode = 0;  // 0: always 1, 1: toggle, 2: random
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------------------------------------- reference model
    logic [ADDR_SZ-1:0] exp_addr_q[$];
    logic [RW+2:0]      exp_q[$];   // {sof, eol, eof, data}

    task automatic build_model(input int wx0, input int wy0, input int ww, input int wh);
        for (int yy = wy0; yy < wy0 + wh; yy++) begin
            for (int xx = wx0; xx < wx0 + ww; xx++) begin
                logic [ADDR_SZ-1:0] a;
                logic s, l, f;
                a = ADDR_SZ'(yy * IMG_W + xx);
                s = (xx == wx0) && (yy == wy0);
                l = (xx == wx0 + ww - 1);
                f = l && (yy == wy0 + wh - 1);
                exp_addr_q.push_back(a);
                exp_q.push_back({s, l, f, mem_word(a)});
            end
        end
    endtask

    // --------------------------------------------- stream monitor
    int en_count, first_en_cyc, last_en_cyc, first_valid_cyc;
    int last_pop_cyc, eof_pop_cyc, pop_count;
    int start_cyc, done_cyc;
    logic done_err, done_busy;
    logic prev_stall = 1'b0;
    logic [RW+2:0] prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_en) begin
                en_count++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                n_tests++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sram_addr_unexpected: got %0d, required no read", sram_addr);
                end else begin
                    logic [ADDR_SZ-1:0] ea;
                    ea = exp_addr_q.pop_front();
                    if (sram_addr !== ea) begin
                        n_fail++;
                        $display("FAIL sram_addr: got %0d, required %0d", sram_addr, ea);
                    end
                end
            end
            if (prev_stall) begin
                n_tests++;
                if ({pix_valid, pix_sof, pix_eol, pix_eof, pix_data} !== {1'b1, prev_word}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b word=%h, required v=1 word=%h",
                             pix_valid, {pix_sof, pix_eol, pix_eof, pix_data}, prev_word);
                end
            end
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                n_tests++;
                pop_count++;
                last_pop_cyc = cyc;
                if (pix_eof) eof_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pixel_unexpected: got %h, required no pixel",
                             {pix_sof, pix_eol, pix_eof, pix_data});
                end else begin
                    logic [RW+2:0] ew;
                    ew = exp_q.pop_front();
                    if ({pix_sof, pix_eol, pix_eof, pix_data} !== ew) begin
                        n_fail++;
                        $display("FAIL pixel: got %h, required %h",
                                 {pix_sof, pix_eol, pix_eof, pix_data}, ew);
                    end
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_word  = {pix_sof, pix_eol, pix_eof, pix_data};
        end
    end

    // ------------------------------------------------- driver tasks
    task automatic clear_stats();
        en_count = 0; first_en_cyc = -1; last_en_cyc = -1; first_valid_cyc = -1;
        last_pop_cyc = -1; eof_pop_cyc = -1; pop_count = 0;
    endtask

    task automatic pulse_start(input int wx0, input int wy0, input int ww, input int wh);
        @(posedge clk);
        #1;
        x0 = 10'(wx0); y0 = 10'(wy0); win_w = 11'(ww); win_h = 11'(wh);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        // Scramble the window inputs: they must have been latched already.
        x0 = 10'($urandom_range(0, 1023)); y0 = 10'($urandom_range(0, 1023));
        win_w = 11'($urandom_range(0, 2047)); win_h = 11'($urandom_range(0, 2047));
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; done_cyc = cyc; done_err = err; done_busy = busy;
                break;
            end
        end
    endtask

    task automatic run_window(input int wx0, input int wy0, input int ww, input int wh, input int mode);
        bit exp_err, got;
        exp_err = (ww == 0) || (wh == 0) || (wx0 + ww > IMG_W) || (wy0 + wh > IMG_H);
        salt = RW'($urandom);
        ready_mode = mode;
        clear_stats();
        if (!exp_err) build_model(wx0, wy0, ww, wh);
        pulse_start(wx0, wy0, ww, wh);
        wait_done(ww * wh * 6 + 40, got);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: got no done, required done (window %0d,%0d %0dx%0d)", wx0, wy0, ww, wh);
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
        end else begin
            n_tests++;
            if (done_err !== exp_err) begin
                n_fail++;
                $display("FAIL err_flag: got %0b, required %0b", done_err, exp_err);
            end
            n_tests++;
            if (done_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_with_done: got %0b, required 0", done_busy);
            end
        end
        n_tests++;
        if (exp_addr_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d reads / %0d pixels missing, required 0",
                     exp_addr_q.size(), exp_q.size());
        end
        exp_addr_q.delete();
        exp_q.delete();
        @(negedge clk);
        n_tests++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_done: got busy/done/err=%b, required 000", {busy, done, err});
        end
    endtask

    // ------------------------------------------------------ scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (all_out !== '0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h state %0d, required 0 state 0", all_out, dbg_state);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h, required 0", all_out);
        end
    endtask

    task automatic test_basic_2x2();
        run_window(0, 0, 2, 2, 0);
        n_tests++;
        if (en_count != 4 || last_en_cyc - first_en_cyc != 3) begin
            n_fail++;
            $display("FAIL basic_reads: got %0d reads over %0d cycles, required 4 over 3",
                     en_count, last_en_cyc - first_en_cyc);
        end
        n_tests++;
        if (first_en_cyc != start_cyc + 1) begin
            n_fail++;
            $display("FAIL first_read_latency: got cycle %0d, required %0d", first_en_cyc, start_cyc + 1);
        end
        n_tests++;
        if (first_valid_cyc != first_en_cyc + 2) begin
            n_fail++;
            $display("FAIL first_valid_latency: got cycle %0d, required %0d", first_valid_cyc, first_en_cyc + 2);
        end
        n_tests++;
        if (done_cyc != eof_pop_cyc + 1) begin
            n_fail++;
            $display("FAIL done_after_eof: got cycle %0d, required %0d", done_cyc, eof_pop_cyc + 1);
        end
    endtask

    task automatic test_stall_toggle();
        run_window(5, 3, 4, 1, 1);
        n_tests++;
        if (pop_count != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d pixels, required 4", pop_count);
        end
    endtask

    task automatic test_frame_edge();
        run_window(1020, 1023, 4, 1, 2);
        n_tests++;
        if (en_count != 4 || eof_pop_cyc < 0) begin
            n_fail++;
            $display("FAIL edge_window: got %0d reads eof_seen=%0b, required 4 reads eof_seen=1",
                     en_count, eof_pop_cyc >= 0);
        end
    endtask

    task automatic test_reject();
        int wins[3][4] = '{'{0, 0, 0, 3}, '{1000, 0, 25, 1}, '{0, 1000, 1, 25}};
        for (int k = 0; k < 3; k++) begin
            run_window(wins[k][0], wins[k][1], wins[k][2], wins[k][3], 0);
            n_tests++;
            if (done_cyc != start_cyc + 1 || en_count != 0) begin
                n_fail++;
                $display("FAIL reject_%0d: got done cycle %0d reads %0d, required cycle %0d reads 0",
                         k, done_cyc, en_count, start_cyc + 1);
            end
        end
    endtask

    task automatic test_mid_start_and_reset();
        bit got;
        int dones;
        // Start pulsed while a frame is in progress must be ignored.
        salt = RW'($urandom);
        ready_mode = 2;
        clear_stats();
        build_model(10, 2, 8, 3);
        pulse_start(10, 2, 8, 3);
        repeat (5) @(posedge clk);
        pulse_start(0, 0, 1, 1);
        wait_done(300, got);
        n_tests++;
        if (!got || done_err !== 1'b0 || exp_q.size() != 0 || pop_count != 24) begin
            n_fail++;
            $display("FAIL mid_start: got done=%0b err=%0b pixels=%0d left=%0d, required 1 0 24 0",
                     got, done_err, pop_count, exp_q.size());
        end
        exp_addr_q.delete();
        exp_q.delete();

        // Reset in the middle of a frame.
        salt = RW'($urandom);
        ready_mode = 0;
        clear_stats();
        build_model(100, 100, 4, 4);
        pulse_start(100, 100, 4, 4);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pop_count >= 3) begin got = 1'b1; break; end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL pre_reset_progress: got %0d pixels, required 3", pop_count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %h, required 0", all_out);
        end
        rst = 1'b0;
        exp_addr_q.delete();
        exp_q.delete();
        clear_stats();
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_tests++;
        if (dones != 0 || en_count != 0 || pop_count != 0) begin
            n_fail++;
            $display("FAIL quiet_after_reset: got dones=%0d reads=%0d pixels=%0d, required 0 0 0",
                     dones, en_count, pop_count);
        end
        run_window(7, 7, 1, 1, 0);
        n_tests++;
        if (en_count != 1 || pop_count != 1) begin
            n_fail++;
            $display("FAIL one_pixel: got %0d reads %0d pixels, required 1 1", en_count, pop_count);
        end
    endtask

    task automatic test_throughput();
        run_window(0, 0, 16, 16, 0);
        n_tests++;
        if (pop_count != 256 || last_pop_cyc - first_valid_cyc != 255) begin
            n_fail++;
            $display("FAIL throughput: got %0d pixels over %0d cycles, required 256 over 255",
                     pop_count, last_pop_cyc - first_valid_cyc);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            int rx, ry, rw, rh;
            rx = (k % 3 == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, 1023);
            ry = (k % 4 == 0) ? $urandom_range(1019, 1023) : $urandom_range(0, 1023);
            rw = $urandom_range(0, 9);
            rh = $urandom_range(0, 4);
            run_window(rx, ry, rw, rh, 2);
        end
    endtask

    // ---------------------------------------------------- main / report
    initial begin
        clear_stats();
        test_reset();
        test_basic_2x2();
        test_stall_toggle();
        test_frame_edge();
        test_reject();
        test_mid_start_and_reset();
        test_throughput();
        test_random();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
